// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: detects the start bit, counts oversampling edges
// and bit positions, and drives the sampler/deserializer/checker enables.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  UART_CLK,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  sampled_bit,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [3:0]            r_bit_cnt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_frame_err;
  logic                  r_data_valid;
  logic                  r_cfg_err;
  logic                  w_prescale_ok;
  logic                  w_bit_end;
  logic                  w_unused;

  // sampled_bit feeds the deserializer directly; the sequencer never looks at it
  assign w_unused = sampled_bit;

  assign w_prescale_ok = (prescale == PRESCALE_W'(8))  ||
                         (prescale == PRESCALE_W'(16)) ||
                         (prescale == PRESCALE_W'(32));
  assign w_bit_end     = (r_edge_cnt == (r_prescale - PRESCALE_W'(1)));

  assign edge_cnt   = r_edge_cnt;
  assign bit_cnt    = r_bit_cnt;
  assign data_valid = r_data_valid;
  assign cfg_err    = r_cfg_err;

  always_ff @(posedge UART_CLK) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_prescale_ok && !RX_IN) begin
          w_state_nxt = START;
        end
      end
      START: begin
        dat_samp_en = 1'b1;
        strt_chk_en = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        dat_samp_en = 1'b1;
        if (w_bit_end) begin
          deser_en = 1'b1;
          if (r_bit_cnt == 4'(DATA_W)) begin
            w_state_nxt = r_par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        dat_samp_en = 1'b1;
        par_chk_en  = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        dat_samp_en = 1'b1;
        stp_chk_en  = 1'b1;
        if (w_bit_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge UART_CLK) begin
    if (rst) begin
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_prescale   <= '0;
      r_par_en     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_data_valid <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_data_valid <= (r_state == STOP) && w_bit_end && !stp_err && !r_frame_err;
      r_cfg_err    <= (w_state_nxt == IDLE) && !w_prescale_ok;
      // the detection cycle is edge 0, so START opens on edge 1
      if (w_state_nxt == IDLE) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (r_state == IDLE) begin
        r_edge_cnt  <= PRESCALE_W'(1);
        r_bit_cnt   <= '0;
        r_prescale  <= prescale;
        r_par_en    <= PAR_EN;
        r_frame_err <= 1'b0;
      end else if (w_bit_end) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + 4'd1;
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
      end
      if ((r_state == PARITY) && w_bit_end && par_err) begin
        r_frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: per-cycle stimulus tables, recorded outputs,
// hand-derived expectations for enable pulses and data_valid timing.
module tb_uart_rx_ctrl;
  localparam int MAXC = 700;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       sampled_bit;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, cfg_err;
  logic [16:0] w_all;

  int n_checks = 0;
  int n_fail   = 0;

  logic       line_v[MAXC];
  logic       gl_v[MAXC];
  logic       pe_v[MAXC];
  logic       se_v[MAXC];
  logic       rst_v[MAXC];
  logic       par_v[MAXC];
  logic [5:0] pres_v[MAXC];
  logic       exp_deser[MAXC];
  logic       exp_dv[MAXC];

  logic        ob_deser[MAXC];
  logic        ob_dv[MAXC];
  logic        ob_dat[MAXC];
  logic        ob_strt[MAXC];
  logic        ob_par[MAXC];
  logic        ob_stp[MAXC];
  logic        ob_cfg[MAXC];
  logic [5:0]  ob_edge[MAXC];
  logic [3:0]  ob_bit[MAXC];
  logic [16:0] ob_all[MAXC];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.PRESCALE_W(6), .DATA_W(8)) dut (
    .UART_CLK    (clk),
    .rst         (rst),
    .RX_IN       (rx_in),
    .prescale    (prescale),
    .PAR_EN      (par_en),
    .sampled_bit (sampled_bit),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .cfg_err     (cfg_err)
  );

  // {edge, bit, samp, deser, strt, par, stp, data_valid, cfg_err}
  assign w_all = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                  par_chk_en, stp_chk_en, data_valid, cfg_err};

  task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic prep();
    for (int c = 0; c < MAXC; c++) begin
      line_v[c]    = 1'b1;
      gl_v[c]      = 1'b0;
      pe_v[c]      = 1'b0;
      se_v[c]      = 1'b0;
      rst_v[c]     = 1'b0;
      par_v[c]     = 1'b0;
      pres_v[c]    = 6'd8;
      exp_deser[c] = 1'b0;
      exp_dv[c]    = 1'b0;
    end
  endtask

  task automatic set_frame(input int s, input int p, input logic [7:0] data,
                           input logic with_par);
    for (int i = 0; i < p; i++) begin
      if (s + i < MAXC) line_v[s + i] = 1'b0;
      for (int k = 0; k < 8; k++)
        if (s + (k + 1) * p + i < MAXC) line_v[s + (k + 1) * p + i] = data[k];
      if (with_par && (s + 9 * p + i < MAXC)) line_v[s + 9 * p + i] = ^data;
    end
  endtask

  task automatic exp_frame(input int s, input int p, input logic with_par);
    for (int k = 1; k <= 8; k++) exp_deser[s + (k + 1) * p - 1] = 1'b1;
    exp_dv[s + (with_par ? 11 : 10) * p] = 1'b1;
  endtask

  task automatic run(input string name, input int n);
    rst = 1'b1; rx_in = 1'b1; sampled_bit = 1'b1; prescale = 6'd8; par_en = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check({name, "_reset"}, -1, 32'(w_all), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < n; c++) begin
      rx_in       = line_v[c];
      sampled_bit = line_v[c];
      prescale    = pres_v[c];
      par_en      = par_v[c];
      strt_glitch = gl_v[c];
      par_err     = pe_v[c];
      stp_err     = se_v[c];
      rst         = rst_v[c];
      #1;
      ob_deser[c] = deser_en;    ob_dv[c]   = data_valid;
      ob_dat[c]   = dat_samp_en; ob_strt[c] = strt_chk_en;
      ob_par[c]   = par_chk_en;  ob_stp[c]  = stp_chk_en;
      ob_cfg[c]   = cfg_err;     ob_edge[c] = edge_cnt;
      ob_bit[c]   = bit_cnt;     ob_all[c]  = w_all;
      check({name, "_deser"}, c, 32'(deser_en), 32'(exp_deser[c]));
      check({name, "_dv"}, c, 32'(data_valid), 32'(exp_dv[c]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // good frame, P=8, no parity
    prep(); set_frame(0, 8, 8'hA5, 1'b0); exp_frame(0, 8, 1'b0);
    run("t1", 90);
    check("t1_samp_c0", 0, 32'(ob_dat[0]), 32'd0);
    check("t1_samp_c1", 1, 32'(ob_dat[1]), 32'd1);
    check("t1_edge_c1", 1, 32'(ob_edge[1]), 32'd1);
    check("t1_bit_c1", 1, 32'(ob_bit[1]), 32'd0);
    check("t1_strt_c7", 7, 32'(ob_strt[7]), 32'd1);
    check("t1_strt_c8", 8, 32'(ob_strt[8]), 32'd0);
    check("t1_edge_c8", 8, 32'(ob_edge[8]), 32'd0);
    check("t1_bit_c8", 8, 32'(ob_bit[8]), 32'd1);
    check("t1_bit_c71", 71, 32'(ob_bit[71]), 32'd8);
    check("t1_stp_c72", 72, 32'(ob_stp[72]), 32'd1);
    check("t1_stp_c79", 79, 32'(ob_stp[79]), 32'd1);
    check("t1_par_c75", 75, 32'(ob_par[75]), 32'd0);
    check("t1_all_c80", 80, 32'(ob_all[80]), 32'h2);

    // start glitch, P=16
    prep(); pres_v[0] = 6'd16;
    for (int c = 0; c < 8; c++) line_v[c] = 1'b0;
    for (int c = 1; c < MAXC; c++) pres_v[c] = 6'd16;
    gl_v[15] = 1'b1;
    run("t2", 200);
    check("t2_edge_c15", 15, 32'(ob_edge[15]), 32'd15);
    check("t2_strt_c15", 15, 32'(ob_strt[15]), 32'd1);
    check("t2_all_c16", 16, 32'(ob_all[16]), 32'd0);

    // parity error, P=8
    prep(); set_frame(0, 8, 8'h3C, 1'b1);
    for (int c = 0; c < MAXC; c++) par_v[c] = 1'b1;
    for (int k = 1; k <= 8; k++) exp_deser[(k + 1) * 8 - 1] = 1'b1;
    pe_v[79] = 1'b1;
    run("t3", 100);
    check("t3_par_c72", 72, 32'(ob_par[72]), 32'd1);
    check("t3_par_c79", 79, 32'(ob_par[79]), 32'd1);
    check("t3_par_c80", 80, 32'(ob_par[80]), 32'd0);
    check("t3_bit_c72", 72, 32'(ob_bit[72]), 32'd9);
    check("t3_bit_c80", 80, 32'(ob_bit[80]), 32'd10);
    for (int c = 80; c < 88; c++) check("t3_stp", c, 32'(ob_stp[c]), 32'd1);
    check("t3_stp_c88", 88, 32'(ob_stp[88]), 32'd0);

    // clean parity frame afterwards: frame-error flag must not linger
    prep(); set_frame(0, 8, 8'h3C, 1'b1);
    for (int c = 0; c < MAXC; c++) par_v[c] = 1'b1;
    exp_frame(0, 8, 1'b1);
    run("t3b", 100);

    // stop error at P=32 then back-to-back good frame
    prep();
    for (int c = 0; c < MAXC; c++) pres_v[c] = 6'd32;
    set_frame(0, 32, 8'h5A, 1'b0); set_frame(320, 32, 8'hC3, 1'b0);
    for (int k = 1; k <= 8; k++) exp_deser[(k + 1) * 32 - 1] = 1'b1;
    exp_frame(320, 32, 1'b0);
    se_v[319] = 1'b1;
    run("t4", 660);
    check("t4_stp_c319", 319, 32'(ob_stp[319]), 32'd1);
    check("t4_bit_c320", 320, 32'(ob_bit[320]), 32'd0);
    check("t4_edge_c321", 321, 32'(ob_edge[321]), 32'd1);
    check("t4_strt_c321", 321, 32'(ob_strt[321]), 32'd1);

    // reset mid-DATA at cycle 40, P=8
    prep(); set_frame(0, 8, 8'hA5, 1'b0);
    for (int c = 40; c < MAXC; c++) line_v[c] = 1'b1;
    for (int k = 1; k <= 4; k++) exp_deser[(k + 1) * 8 - 1] = 1'b1;
    rst_v[40] = 1'b1;
    run("t5", 100);
    check("t5_all_c41", 41, 32'(ob_all[41]), 32'd0);

    // illegal prescale blocks start; mid-frame config changes are ignored
    prep();
    for (int c = 0; c < 25; c++) pres_v[c] = 6'd12;
    for (int c = 50; c < MAXC; c++) begin
      pres_v[c] = 6'd16;
      par_v[c]  = 1'b1;
    end
    for (int c = 0; c <= 20; c++) line_v[c] = 1'b0;
    set_frame(30, 8, 8'h96, 1'b0); exp_frame(30, 8, 1'b0);
    run("t6", 130);
    check("t6_cfg_c1", 1, 32'(ob_cfg[1]), 32'd1);
    check("t6_cfg_c24", 24, 32'(ob_cfg[24]), 32'd1);
    check("t6_samp_c5", 5, 32'(ob_dat[5]), 32'd0);
    check("t6_edge_c20", 20, 32'(ob_edge[20]), 32'd0);
    check("t6_cfg_c26", 26, 32'(ob_cfg[26]), 32'd0);
    check("t6_edge_c31", 31, 32'(ob_edge[31]), 32'd1);
    check("t6_cfg_c60", 60, 32'(ob_cfg[60]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
